// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default constants for the unified-memory
// arbiter between the instruction-fetch port and the data (LW/SW) port.
//   arb_state_t : arbiter sequencing state (IDLE/BUSY/DONE)
//   gnt_t       : which port owns the current access
//   op_t        : access kind latched into the command registers
//   cnt_width() : bit width needed to hold a latency countdown of lat-1
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int MEM_LAT_DEF    = 4;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // A latency of 1 loads a count of 0, which still needs one bit.
    function automatic int cnt_width(input int lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every request, response and memory-side signal
// of the arbiter.
//   slave  modport : the arbiter (takes requests and mem_rdata, drives the
//                    per-port responses, stalls and the memory command)
//   master modport : the pipeline plus memory macro around the arbiter
// Handshake: if_req and d_re/d_we are level requests held by the requester
// until the matching one-cycle done pulse; the arbiter samples them only
// while idle, so a requester drops or changes its request by the cycle
// after done. stall_* report "request present and not completing now".
// state is a debug view of the arbiter sequencing state.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    import mem_arb_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              d_re;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              stall_if;
    logic              stall_d;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    arb_state_t        state;

    modport slave (
        input  if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_done, d_rdata, d_done, stall_if, stall_d,
               mem_addr, mem_re, mem_we, mem_wdata, state
    );

    modport master (
        output if_req, if_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_done, d_rdata, d_done, stall_if, stall_d,
               mem_addr, mem_re, mem_we, mem_wdata, state
    );

endinterface

// File: rtl/mem_lat_counter.sv
// mem_lat_counter: down-counter timing the memory access latency.
//   clk, rst    : clock, synchronous active-high reset (count -> 0)
//   load_i      : load load_val_i (has priority over decrement)
//   load_val_i  : value loaded at the start of an access
//   dec_i       : decrement by one; holds at zero
//   zero_o      : count is zero (combinational from the count register)
module mem_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port fixed-latency memory between the
// instruction-fetch port and the data port of the pipelined CPU.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave -- fetch request/response, data
//              request/response, stalls, memory command and read data
// One access at a time: IDLE grants (data beats fetch), BUSY holds the
// command for MEM_LAT cycles and captures read data on the last one, DONE
// pulses the granted port's done and returns to IDLE.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN -- after STARVE_MAX
// consecutive data grants made while fetch was waiting, the next
// arbitration goes to fetch. Without it data always wins.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 4,
    parameter int STARVE_MAX = 3
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    localparam int CW = cnt_width(MEM_LAT);

    arb_state_t        state_q;
    gnt_t              gnt_q;
    op_t               op_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_done_q;
    logic              d_done_q;

    logic d_req;
    logic any_req;
    logic force_if;
    gnt_t gnt_sel;
    logic lat_load;
    logic lat_dec;
    logic lat_zero;

    assign d_req   = bus.d_re | bus.d_we;
    assign any_req = d_req | bus.if_req;
    assign gnt_sel = (d_req && !force_if) ? GNT_D : GNT_IF;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Consecutive data grants won while fetch was also waiting; saturates.
    logic [SW-1:0] starve_q;

    assign force_if = bus.if_req && (starve_q >= SW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else if ((state_q == IDLE) && any_req) begin
            if ((gnt_sel == GNT_D) && bus.if_req) begin
                if (starve_q < SW'(STARVE_MAX)) begin
                    starve_q <= starve_q + 1'b1;
                end
            end else begin
                starve_q <= '0;
            end
        end
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;
    assign force_if = 1'b0;
`endif

    assign lat_load = (state_q == IDLE) && any_req;
    assign lat_dec  = (state_q == BUSY);

    mem_lat_counter #(.W(CW)) u_lat (
        .clk        (clk),
        .rst        (rst),
        .load_i     (lat_load),
        .load_val_i (CW'(MEM_LAT - 1)),
        .dec_i      (lat_dec),
        .zero_o     (lat_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_IF;
            op_q        <= OP_RD;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q   <= gnt_sel;
                        state_q <= BUSY;
                        if (gnt_sel == GNT_D) begin
                            // Read+write together is a store.
                            op_q        <= bus.d_we ? OP_WR : OP_RD;
                            mem_re_q    <= !bus.d_we;
                            mem_we_q    <= bus.d_we;
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                        end else begin
                            op_q        <= OP_RD;
                            mem_re_q    <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (lat_zero) begin
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= DONE;
                        if (gnt_q == GNT_IF) begin
                            if_done_q <= 1'b1;
                            if (op_q == OP_RD) begin
                                if_rdata_q <= bus.mem_rdata;
                            end
                        end else begin
                            d_done_q <= 1'b1;
                            if (op_q == OP_RD) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.state     = state_q;

    // Stalls drop in the done cycle itself so the stage advances with no
    // extra bubble.
    assign bus.stall_if = bus.if_req & ~if_done_q;
    assign bus.stall_d  = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized traffic, all
// checked cycle by cycle against a transaction-level schedule model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int LAT  = 4;
    localparam int SMAX = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- check bookkeeping ----------------
    int cyc       = 0;
    int chk_total = 0;
    int chk_pass  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, act, exp);
    endtask

    // ---------------- reference model state ----------------
    // One access = grant cycle s, command on cycles s+1..s+LAT, done on
    // s+LAT+1, next sampling at s+LAT+2.
    bit              act_valid = 0;
    int              act_start = 0;
    bit              act_d     = 0;
    bit              act_wr    = 0;
    logic [AW-1:0]   act_addr  = '0;
    logic [DW-1:0]   act_wdata = '0;
    int              starve    = 0;
    logic [DW-1:0]   exp_if_rdata = '0;
    logic [DW-1:0]   exp_d_rdata  = '0;
    logic [DW:0]     exp_q[$];          // {port_is_data, returned data or 0}
    bit              after_reset = 0;
    bit              e_busy = 0, e_if_done = 0, e_d_done = 0;
    bit              rand_mem = 0;
    int              obs_if_done, obs_d_done, obs_if_first, obs_d_first;

    task automatic model_update();
        bit idle;
        bit d_req;
        bit take_d;
        if (rst) begin
            act_valid    = 0;
            starve       = 0;
            exp_if_rdata = '0;
            exp_d_rdata  = '0;
            exp_q.delete();
            after_reset  = 1;
        end else begin
            if (act_valid && cyc == act_start + LAT) begin
                if (!act_wr) begin
                    if (act_d) exp_d_rdata = bus.mem_rdata;
                    else       exp_if_rdata = bus.mem_rdata;
                end
                exp_q.push_back({act_d, act_wr ? 16'h0000 : bus.mem_rdata});
            end
            idle  = !act_valid || (cyc >= act_start + LAT + 2);
            d_req = bus.d_re || bus.d_we;
            if (idle && (d_req || bus.if_req)) begin
                take_d = d_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
                if (bus.if_req && starve >= SMAX) take_d = 0;
`endif
                act_valid = 1;
                act_start = cyc;
                act_d     = take_d;
                if (take_d) begin
                    act_wr    = bus.d_we;
                    act_addr  = bus.d_addr;
                    act_wdata = bus.d_wdata;
                    starve    = bus.if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
                end else begin
                    act_wr    = 0;
                    act_addr  = bus.if_addr;
                    act_wdata = '0;
                    starve    = 0;
                end
            end
        end
    endtask

    // One clock: check stalls for the current inputs, advance the model,
    // cross the edge and check the registered outputs of the new cycle.
    task automatic step();
        logic [DW:0] e;
        #1;
        check("stall_if", bus.stall_if, bus.if_req && !e_if_done);
        check("stall_d", bus.stall_d, (bus.d_re || bus.d_we) && !e_d_done);
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        e_busy    = act_valid && (cyc > act_start) && (cyc <= act_start + LAT);
        e_if_done = act_valid && (cyc == act_start + LAT + 1) && !act_d;
        e_d_done  = act_valid && (cyc == act_start + LAT + 1) && act_d;
        check("mem_re", bus.mem_re, e_busy && !act_wr);
        check("mem_we", bus.mem_we, e_busy && act_wr);
        if (e_busy) check("mem_addr", bus.mem_addr, act_addr);
        if (e_busy && act_wr) check("mem_wdata", bus.mem_wdata, act_wdata);
        check("if_done", bus.if_done, e_if_done);
        check("d_done", bus.d_done, e_d_done);
        check("if_rdata", bus.if_rdata, exp_if_rdata);
        check("d_rdata", bus.d_rdata, exp_d_rdata);
        if (after_reset) begin
            check("rst_state", bus.state, IDLE);
            check("rst_mem_addr", bus.mem_addr, 16'h0000);
            check("rst_mem_wdata", bus.mem_wdata, 16'h0000);
            after_reset = 0;
        end
        if (bus.if_done === 1'b1 || bus.d_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_done", {bus.d_done, e[DW-1:0] == '0 ? e[DW-1:0] :
                      (bus.d_done ? bus.d_rdata : bus.if_rdata)}, e);
            end
        end
        if (bus.if_done === 1'b1) begin
            obs_if_done++;
            if (obs_if_first < 0) obs_if_first = cyc;
        end
        if (bus.d_done === 1'b1) begin
            obs_d_done++;
            if (obs_d_first < 0) obs_d_first = cyc;
        end
        if (rand_mem) bus.mem_rdata = 16'($urandom);
    endtask

    // ---------------- driver tasks ----------------
    task automatic run(input int n, input bit hold_d);
        for (int i = 0; i < n; i++) begin
            step();
            if (e_if_done) bus.if_req = 1'b0;
            if (e_d_done && !hold_d) begin
                bus.d_re = 1'b0;
                bus.d_we = 1'b0;
            end
        end
    endtask

    task automatic clear_obs();
        obs_if_done  = 0;
        obs_d_done   = 0;
        obs_if_first = -1;
        obs_d_first  = -1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        bus.if_req = 1'b0;
        bus.d_re   = 1'b0;
        bus.d_we   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic rand_drive();
        rst = ($urandom_range(0, 299) == 0);
        if (!bus.if_req || e_if_done) begin
            bus.if_req  = ($urandom_range(0, 2) != 0);
            bus.if_addr = 16'($urandom);
        end
        if (!(bus.d_re || bus.d_we) || e_d_done) begin
            case ($urandom_range(0, 4))
                0:       begin bus.d_re = 1'b0; bus.d_we = 1'b0; end
                1, 2:    begin bus.d_re = 1'b1; bus.d_we = 1'b0; end
                3:       begin bus.d_re = 1'b0; bus.d_we = 1'b1; end
                default: begin bus.d_re = 1'b1; bus.d_we = 1'b1; end
            endcase
            bus.d_addr  = 16'($urandom);
            bus.d_wdata = 16'($urandom);
        end
    endtask

    // ---------------- stimulus ----------------
    int c0;
    initial begin
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_re      = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = 16'hB123;
        clear_obs();

        // Single fetch.
        apply_reset();
        clear_obs();
        c0 = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        run(8, 0);
        check("t1_if_done_cycle", obs_if_first - c0, 5);
        check("t1_if_rdata", bus.if_rdata, 16'hB123);

        // Fetch and load together: data first, fetch next.
        clear_obs();
        c0 = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0020;
        bus.d_re    = 1'b1;
        bus.d_addr  = 16'h0030;
        run(14, 0);
        check("t2_d_done_cycle", obs_d_first - c0, 5);
        check("t2_if_done_cycle", obs_if_first - c0, 11);

        // Store after reset leaves d_rdata at 0.
        apply_reset();
        clear_obs();
        c0 = cyc;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0040;
        bus.d_wdata = 16'hBEEF;
        run(8, 0);
        check("t3_d_done_cycle", obs_d_first - c0, 5);
        check("t3_d_rdata", bus.d_rdata, 16'h0000);

        // Read and write together act as a store.
        clear_obs();
        bus.d_re    = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0044;
        bus.d_wdata = 16'h1357;
        run(8, 0);
        check("t4_d_done_count", obs_d_done, 1);
        check("t4_d_rdata", bus.d_rdata, 16'h0000);

        // Reset during the second BUSY cycle aborts with no done.
        clear_obs();
        c0 = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0050;
        run(2, 0);
        rst        = 1'b1;
        bus.if_req = 1'b0;
        step();
        check("t5_mem_re_after_rst", bus.mem_re, 1'b0);
        rst = 1'b0;
        run(6, 0);
        check("t5_no_done", obs_if_done, 0);

        // Continuous loads with fetch waiting.
        apply_reset();
        clear_obs();
        c0 = cyc;
        bus.d_re    = 1'b1;
        bus.d_addr  = 16'h0060;
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0070;
        run(30, 1);
`ifdef MEM_ARB_STARVE_GUARD_EN
        check("t6_fetch_after_three", obs_if_first - c0, 23);
`else
        check("t6_fetch_starved", obs_if_done, 0);
        check("t6_data_grants", obs_d_done, 5);
`endif
        bus.d_re = 1'b0;
        run(10, 0);
        check("t6_fetch_total", obs_if_done, 1);

        // Randomized traffic with random memory data and occasional reset.
        rand_mem = 1;
        for (int i = 0; i < 4000; i++) begin
            step();
            rand_drive();
        end
        rst        = 1'b0;
        bus.if_req = 1'b0;
        bus.d_re   = 1'b0;
        bus.d_we   = 1'b0;
        run(12, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencing controller that shares one single-port, fixed-latency unified memory between the instruction-fetch port and the data (LW/SW) port of the 16-bit pipelined CPU. It sits between the IF/MEM stages and the memory macro. It accepts level-held requests from both ports and grants one at a time. It holds the memory command stable for the full access latency, returns read data in a per-port register with a one-cycle done pulse, and drives per-port stall signals into the pipeline control.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 4, memory access cycles (≥1); mem_rdata valid in last BUSY cycle
- STARVE_MAX, 3, consecutive data grants before fetch is forced (guard only)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level-held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered
- if_done  out  1  one-cycle pulse, if_rdata valid
- d_re  in  1  data read request (LW), level-held
- d_we  in  1  data write request (SW), level-held
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_done  out  1  one-cycle pulse, data access complete
- stall_if  out  1  if_req & !if_done
- stall_d  out  1  (d_re|d_we) & !d_done
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any request is pending, grant it, latch its addr/wdata/op into command registers, load the latency counter with MEM_LAT-1, and go to BUSY. With no request, stay in IDLE.
- Priority: the data port beats fetch when both are pending, because the MEM stage is older.
- d_re and d_we both high: treated as a write. d_rdata is not updated.
- BUSY: mem_addr, mem_re/mem_we and mem_wdata are driven from the command registers and held constant. The counter decrements each cycle. At count 0, mem_rdata is captured into the granted port's rdata register on a read, and the state moves to DONE.
- DONE: the granted port's done pulses for 1 cycle. mem_re and mem_we are 0. The state always returns to IDLE.
- Requests are sampled only in IDLE. The finishing requester must deassert or change its request by the cycle after done.
- The rdata registers hold their value until the next completed read on the same port.
- Writes: memory commits on the last BUSY cycle. d_rdata is unchanged.

## Timing
- Reset values: state IDLE, counter 0, all outputs 0, including if_rdata and d_rdata.
- Request seen in IDLE at cycle 0: BUSY covers cycles 1..MEM_LAT, done is at cycle MEM_LAT+1, and the next grant happens at MEM_LAT+2 (IDLE). Throughput is 1 access per MEM_LAT+2 cycles.
- MEM_LAT=1: BUSY lasts exactly 1 cycle.
- rst asserted in any state: the state is IDLE on the next edge. Any in-flight access is aborted, mem_re/mem_we drop, and no done is issued. A write aborted by reset is undefined in memory.
- stall_* are combinational from the request inputs and done registers. They have no extra latency.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: a saturating counter counts consecutive data grants while if_req is pending. When it reaches STARVE_MAX, the next IDLE arbitration grants fetch. The counter resets on any fetch grant, and on any data grant made while if_req is low.
- Not defined: strict data-over-fetch priority. STARVE_MAX is unused.

## Structure
- Package mem_arb_pkg contains:
  - the state enum (IDLE/BUSY/DONE)
  - the grant typedef (GNT_IF/GNT_D)
  - the op typedef (OP_RD/OP_WR)
  - default parameter constants
- One sub-module, mem_lat_counter: load value, decrement enable, and a zero flag. It is instantiated once for the latency countdown.

## Test plan
- Single fetch, MEM_LAT=4, if_addr=0x0010, mem_rdata=0xB123 in the last BUSY cycle → mem_re high for cycles 1–4 with mem_addr=0x0010; if_done pulses at cycle 5 with if_rdata=0xB123; stall_if high for cycles 0–4.
- Simultaneous if_req and d_re at cycle 0 → data granted first (d_done at cycle 5); fetch granted at cycle 6 (if_done at cycle 11).
- SW d_addr=0x0040, d_wdata=0xBEEF → mem_we=1 with stable addr/data for 4 cycles; d_done pulses; d_rdata stays 0.
- d_re=d_we=1 → behaves as a write; no d_rdata update.
- rst asserted at cycle 2 of BUSY → mem_re=0 and state IDLE on the next edge; no done pulse; all outputs 0.
- Guard on, STARVE_MAX=3, d_re held continuously with if_req pending → three data grants, then one fetch grant; guard off → fetch never granted while d_re is held.
